// File: rtl/timekeeper_core.sv
// hh:mm:ss timekeeper with preset load, run gate, press/auto-repeat adjustment,
// day-rollover pulse and a 12 h display view.
module timekeeper_core #(
  parameter int SEC_MOD   = 60,
  parameter int MIN_MOD   = 60,
  parameter int HOUR_MOD  = 24,
  parameter int RPT_DELAY = 3,
  localparam int SW = $clog2(SEC_MOD),
  localparam int MW = $clog2(MIN_MOD),
  localparam int HW = ($clog2(HOUR_MOD) > 4) ? $clog2(HOUR_MOD) : 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1hz,
  input  logic          tick_rpt,
  input  logic          up_n,
  input  logic          down_n,
  input  logic [1:0]    mode,
  input  logic          run,
  input  logic          load,
  input  logic [SW-1:0] load_sec,
  input  logic [MW-1:0] load_min,
  input  logic [HW-1:0] load_hour,
  output logic [SW-1:0] second,
  output logic [MW-1:0] minute,
  output logic [HW-1:0] hour,
  output logic [HW-1:0] hour12,
  output logic          pm,
  output logic          day_tick
);

  localparam int CW = (RPT_DELAY > 0) ? $clog2(RPT_DELAY + 1) : 1;
  localparam logic [SW-1:0] SEC_MAX  = SW'(SEC_MOD - 1);
  localparam logic [MW-1:0] MIN_MAX  = MW'(MIN_MOD - 1);
  localparam logic [HW-1:0] HOUR_MAX = HW'(HOUR_MOD - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(RPT_DELAY);

  logic          req_up, req_dn, req_act;
  logic          prev_up, prev_dn, armed;
  logic [1:0]    prev_mode;
  logic [CW-1:0] hold_cnt;
  logic          adjust_en, mode_chg, press, rpt_step, step;
  logic [SW-1:0] sec_inc, sec_dec, sec_ld;
  logic [MW-1:0] min_inc, min_dec, min_ld;
  logic [HW-1:0] hour_inc, hour_dec, hour_ld;
  logic          sec_max, min_max, hour_max;

  // Exactly one button low is a request; both low or both high is not.
  assign req_up    = ~up_n &  down_n;
  assign req_dn    =  up_n & ~down_n;
  assign req_act   = req_up | req_dn;
  assign adjust_en = (mode != 2'b00);
  assign mode_chg  = (mode != prev_mode);

  // A press is any change into an active request, including a direction flip.
  // armed drops on reset so a button held through reset must be released first.
  assign press    = req_act & armed & ({req_up, req_dn} != {prev_up, prev_dn});
  assign rpt_step = req_act & armed & ~press & ~mode_chg & tick_rpt & (hold_cnt == HOLD_MAX);
  assign step     = adjust_en & (press | rpt_step);

  assign sec_max  = (second == SEC_MAX);
  assign min_max  = (minute == MIN_MAX);
  assign hour_max = (hour == HOUR_MAX);
  assign sec_inc  = sec_max  ? '0 : second + SW'(1);
  assign min_inc  = min_max  ? '0 : minute + MW'(1);
  assign hour_inc = hour_max ? '0 : hour + HW'(1);
  assign sec_dec  = (second == '0) ? SEC_MAX  : second - SW'(1);
  assign min_dec  = (minute == '0) ? MIN_MAX  : minute - MW'(1);
  assign hour_dec = (hour == '0)   ? HOUR_MAX : hour - HW'(1);

  // Extra MSB keeps the range check valid when a modulus is a power of two.
  assign sec_ld  = ({1'b0, load_sec}  < (SW+1)'(SEC_MOD))  ? load_sec  : '0;
  assign min_ld  = ({1'b0, load_min}  < (MW+1)'(MIN_MOD))  ? load_min  : '0;
  assign hour_ld = ({1'b0, load_hour} < (HW+1)'(HOUR_MOD)) ? load_hour : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_up   <= 1'b0;
      prev_dn   <= 1'b0;
      prev_mode <= 2'b00;
      armed     <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      prev_up   <= req_up;
      prev_dn   <= req_dn;
      prev_mode <= mode;
      if (!req_act) armed <= 1'b1;
      if (!adjust_en || !req_act || !armed || press || mode_chg)
        hold_cnt <= '0;
      else if (tick_rpt && hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      second   <= '0;
      minute   <= '0;
      hour     <= '0;
      day_tick <= 1'b0;
    end else begin
      day_tick <= 1'b0;
      if (load) begin
        second <= sec_ld;
        minute <= min_ld;
        hour   <= hour_ld;
      end else if (adjust_en) begin
        if (step) begin
          case (mode)
            2'b01:   second <= req_up ? sec_inc  : sec_dec;
            2'b10:   minute <= req_up ? min_inc  : min_dec;
            default: hour   <= req_up ? hour_inc : hour_dec;
          endcase
        end
      end else if (run && tick_1hz) begin
        second <= sec_inc;
        if (sec_max) minute <= min_inc;
        if (sec_max && min_max) hour <= hour_inc;
        day_tick <= sec_max & min_max & hour_max;
      end
    end
  end

  generate
    if (HOUR_MOD == 24) begin : g_h24
      assign hour12 = (hour == '0) ? HW'(12) :
                      (hour > HW'(12)) ? hour - HW'(12) : hour;
      assign pm     = (hour >= HW'(12));
    end else begin : g_hx
      assign hour12 = hour;
      assign pm     = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench: default 60/60/24 instance plus a 10/10/12 instance sharing stimulus.
module tb_timekeeper_core;
  logic clk = 1'b0;
  logic rst, tick_1hz, tick_rpt, up_n, down_n, run, load;
  logic [1:0] mode;
  logic [5:0] load_sec0, load_min0, second0, minute0;
  logic [4:0] load_hour0, hour0, hour12_0;
  logic pm0, day_tick0;
  logic [3:0] load_sec1, load_min1, load_hour1, second1, minute1, hour1, hour12_1;
  logic pm1, day_tick1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timekeeper_core dut0 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_rpt(tick_rpt),
    .up_n(up_n), .down_n(down_n), .mode(mode), .run(run), .load(load),
    .load_sec(load_sec0), .load_min(load_min0), .load_hour(load_hour0),
    .second(second0), .minute(minute0), .hour(hour0), .hour12(hour12_0),
    .pm(pm0), .day_tick(day_tick0)
  );

  timekeeper_core #(.SEC_MOD(10), .MIN_MOD(10), .HOUR_MOD(12)) dut1 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_rpt(tick_rpt),
    .up_n(up_n), .down_n(down_n), .mode(mode), .run(run), .load(load),
    .load_sec(load_sec1), .load_min(load_min1), .load_hour(load_hour1),
    .second(second1), .minute(minute1), .hour(hour1), .hour12(hour12_1),
    .pm(pm1), .day_tick(day_tick1)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load0(input int h, input int m, input int s);
    load_hour0 = 5'(h); load_min0 = 6'(m); load_sec0 = 6'(s);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic pulse_rpt();
    tick_rpt = 1'b1;
    cyc();
    tick_rpt = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({hour0, minute0, second0} !== 17'd0 || hour12_0 !== 5'd12 || pm0 !== 1'b0 || day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL reset got %0d:%0d:%0d h12=%0d pm=%0b dt=%0b exp 0:0:0 h12=12 pm=0 dt=0",
               hour0, minute0, second0, hour12_0, pm0, day_tick0);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_rollover();
    do_load0(23, 59, 58);
    run = 1'b1;
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    checks++;
    if ({hour0, minute0, second0} !== {5'd23, 6'd59, 6'd59} || day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL roll_first got %0d:%0d:%0d dt=%0b exp 23:59:59 dt=0", hour0, minute0, second0, day_tick0);
    end
    checks++;
    if (hour12_0 !== 5'd11 || pm0 !== 1'b1) begin
      errors++;
      $display("FAIL roll_h12_23 got h12=%0d pm=%0b exp h12=11 pm=1", hour12_0, pm0);
    end
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    checks++;
    if ({hour0, minute0, second0} !== 17'd0 || day_tick0 !== 1'b1) begin
      errors++;
      $display("FAIL roll_wrap got %0d:%0d:%0d dt=%0b exp 0:0:0 dt=1", hour0, minute0, second0, day_tick0);
    end
    checks++;
    if (hour12_0 !== 5'd12 || pm0 !== 1'b0) begin
      errors++;
      $display("FAIL roll_h12 got h12=%0d pm=%0b exp h12=12 pm=0", hour12_0, pm0);
    end
    cyc();
    checks++;
    if (day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL roll_dt_width got dt=%0b exp 0", day_tick0);
    end
  endtask

  task automatic test_load_priority();
    tick_1hz = 1'b1;
    do_load0(12, 34, 56);
    tick_1hz = 1'b0;
    checks++;
    if ({hour0, minute0, second0} !== {5'd12, 6'd34, 6'd56} || hour12_0 !== 5'd12 || pm0 !== 1'b1 || day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL load_wins got %0d:%0d:%0d h12=%0d pm=%0b dt=%0b exp 12:34:56 h12=12 pm=1 dt=0",
               hour0, minute0, second0, hour12_0, pm0, day_tick0);
    end
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    checks++;
    if ({hour0, minute0, second0} !== {5'd12, 6'd34, 6'd57}) begin
      errors++;
      $display("FAIL load_then_tick got %0d:%0d:%0d exp 12:34:57", hour0, minute0, second0);
    end
    do_load0(13, 60, 63);
    checks++;
    if ({hour0, minute0, second0} !== {5'd13, 6'd0, 6'd0} || hour12_0 !== 5'd1 || pm0 !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp got %0d:%0d:%0d h12=%0d pm=%0b exp 13:0:0 h12=1 pm=1",
               hour0, minute0, second0, hour12_0, pm0);
    end
  endtask

  task automatic test_hour_repeat();
    do_load0(0, 34, 57);
    mode = 2'b11;
    down_n = 1'b0;
    cyc();
    checks++;
    if (hour0 !== 5'd23) begin
      errors++;
      $display("FAIL rpt_press got hour=%0d exp 23", hour0);
    end
    pulse_rpt(); pulse_rpt(); pulse_rpt();
    checks++;
    if (hour0 !== 5'd23) begin
      errors++;
      $display("FAIL rpt_hold got hour=%0d exp 23", hour0);
    end
    pulse_rpt();
    checks++;
    if (hour0 !== 5'd22) begin
      errors++;
      $display("FAIL rpt_step4 got hour=%0d exp 22", hour0);
    end
    pulse_rpt();
    checks++;
    if ({hour0, minute0, second0} !== {5'd21, 6'd34, 6'd57} || day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL rpt_step5 got %0d:%0d:%0d dt=%0b exp 21:34:57 dt=0", hour0, minute0, second0, day_tick0);
    end
    down_n = 1'b1;
    cyc();
  endtask

  task automatic test_minute_adjust();
    mode = 2'b10;
    do_load0(21, 59, 57);
    up_n = 1'b0;
    cyc();
    up_n = 1'b1;
    checks++;
    if ({hour0, minute0, second0} !== {5'd21, 6'd0, 6'd57}) begin
      errors++;
      $display("FAIL min_wrap got %0d:%0d:%0d exp 21:0:57", hour0, minute0, second0);
    end
    cyc();
    up_n = 1'b0; down_n = 1'b0;
    cyc(); pulse_rpt(); pulse_rpt();
    up_n = 1'b1; down_n = 1'b1;
    cyc();
    checks++;
    if ({hour0, minute0, second0} !== {5'd21, 6'd0, 6'd57}) begin
      errors++;
      $display("FAIL min_both got %0d:%0d:%0d exp 21:0:57", hour0, minute0, second0);
    end
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    end
    checks++;
    if ({hour0, minute0, second0} !== {5'd21, 6'd0, 6'd57} || day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL min_frozen got %0d:%0d:%0d exp 21:0:57", hour0, minute0, second0);
    end
    mode = 2'b00;
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    checks++;
    if (second0 !== 6'd58) begin
      errors++;
      $display("FAIL resume got sec=%0d exp 58", second0);
    end
    run = 1'b0;
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    checks++;
    if (second0 !== 6'd58) begin
      errors++;
      $display("FAIL run_off got sec=%0d exp 58", second0);
    end
  endtask

  task automatic test_small_mod();
    mode = 2'b00;
    run = 1'b1;
    load_hour1 = 4'd11; load_min1 = 4'd9; load_sec1 = 4'd9;
    do_load0(1, 2, 3);
    checks++;
    if (hour12_1 !== 4'd11 || pm1 !== 1'b0) begin
      errors++;
      $display("FAIL mod12_view got h12=%0d pm=%0b exp h12=11 pm=0", hour12_1, pm1);
    end
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    checks++;
    if ({hour1, minute1, second1} !== 12'd0 || day_tick1 !== 1'b1) begin
      errors++;
      $display("FAIL mod12_wrap got %0d:%0d:%0d dt=%0b exp 0:0:0 dt=1", hour1, minute1, second1, day_tick1);
    end
    load_hour1 = 4'd15; load_min1 = 4'd3; load_sec1 = 4'd3;
    do_load0(1, 2, 3);
    checks++;
    if ({hour1, minute1, second1} !== {4'd0, 4'd3, 4'd3} || pm1 !== 1'b0 || hour12_1 !== 4'd0 || day_tick1 !== 1'b0) begin
      errors++;
      $display("FAIL mod12_clamp got %0d:%0d:%0d h12=%0d pm=%0b exp 0:3:3 h12=0 pm=0",
               hour1, minute1, second1, hour12_1, pm1);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    mode = 2'b01;
    do_load0(5, 6, 7);
    up_n = 1'b0;
    cyc();
    checks++;
    if (second0 !== 6'd8) begin
      errors++;
      $display("FAIL hold_press got sec=%0d exp 8", second0);
    end
    pulse_rpt(); pulse_rpt(); pulse_rpt(); pulse_rpt();
    checks++;
    if (second0 !== 6'd9) begin
      errors++;
      $display("FAIL hold_rpt got sec=%0d exp 9", second0);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({hour0, minute0, second0} !== 17'd0 || hour12_0 !== 5'd12 || pm0 !== 1'b0 || day_tick0 !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset got %0d:%0d:%0d h12=%0d pm=%0b exp 0:0:0 h12=12 pm=0",
               hour0, minute0, second0, hour12_0, pm0);
    end
    cyc();
    for (int i = 0; i < 5; i++) pulse_rpt();
    checks++;
    if (second0 !== 6'd0) begin
      errors++;
      $display("FAIL hold_locked got sec=%0d exp 0", second0);
    end
    up_n = 1'b1; cyc();
    up_n = 1'b0; cyc();
    checks++;
    if (second0 !== 6'd1) begin
      errors++;
      $display("FAIL hold_repress got sec=%0d exp 1", second0);
    end
    up_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; tick_rpt = 1'b0; up_n = 1'b1; down_n = 1'b1;
    mode = 2'b00; run = 1'b0; load = 1'b0;
    load_sec0 = '0; load_min0 = '0; load_hour0 = '0;
    load_sec1 = '0; load_min1 = '0; load_hour1 = '0;
    test_reset();
    test_rollover();
    test_load_priority();
    test_hour_repeat();
    test_minute_adjust();
    test_small_mod();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
